// File: rtl/excess5_pkg.sv
// Shared constants and state encoding for the offset-5 digit receive path.
package excess5_pkg;

  localparam logic [3:0] CODE_OFFSET = 4'd5;
  localparam logic [3:0] CODE_MIN    = 4'd5;
  localparam logic [3:0] CODE_MAX    = 4'd14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/excess5_digit_dec.sv
// Combinational offset-5 to BCD digit decoder; the inverse of the digit encoder.
module excess5_digit_dec
  import excess5_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] digit,
  output logic       illegal
);

  // Decode one code; out-of-range codes map to digit 0 and raise illegal.
  always_comb begin
    illegal = (code < CODE_MIN) || (code > CODE_MAX);
    if (illegal) begin
      digit = 4'd0;
    end else begin
      digit = code - CODE_OFFSET;
    end
  end

endmodule

// File: rtl/excess5_frame_decoder.sv
// Collects offset-5 coded digits into a right-justified packed BCD frame and
// presents it with error/truncation flags and a saturating illegal-code count.
module excess5_frame_decoder
  import excess5_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int ERRW   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_code,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [3:0]            out_ndigits,
  output logic                  out_err,
  output logic                  out_trunc,
  output logic [ERRW-1:0]       err_count,
  input  logic                  clear
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [3:0] DIGITS_L = 4'(DIGITS);

  state_e          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [3:0]      count_q, count_d;
  logic            err_q, err_d;
  logic            trunc_q, trunc_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic [ERRW-1:0] ecnt_q, ecnt_d;

  logic [3:0]      digit_s;
  logic            illegal_s;
  logic            accept_s;
  logic [3:0]      count_next_s;

  excess5_digit_dec u_dec (
    .code    (in_code),
    .digit   (digit_s),
    .illegal (illegal_s)
  );

  assign accept_s     = in_valid & ready_q;
  assign count_next_s = count_q + 4'd1;

  // Frame state machine: shift in digits, decide end of frame, release on handshake.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    err_d   = err_q;
    trunc_d = trunc_q;
    case (state_q)
      IDLE, COLLECT: begin
        // IDLE holds word/count at zero, so one path serves the first digit too.
        if (accept_s) begin
          word_d  = (word_q << 4) | W'(digit_s);
          count_d = count_next_s;
          err_d   = err_q | illegal_s;
          if (in_last) begin
            state_d = HOLD;
            trunc_d = 1'b0;
          end else if (count_next_s == DIGITS_L) begin
            state_d = HOLD;
            trunc_d = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          word_d  = '0;
          count_d = 4'd0;
          err_d   = 1'b0;
          trunc_d = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        word_d  = '0;
        count_d = 4'd0;
        err_d   = 1'b0;
        trunc_d = 1'b0;
      end
    endcase
  end

  // Handshake flags follow the next state so they line up with the registered frame.
  always_comb begin
    valid_d = (state_d == HOLD);
    ready_d = (state_d != HOLD);
  end

  // Saturating illegal-code counter; clear takes priority over a same-cycle increment.
  always_comb begin
    if (clear) begin
      ecnt_d = '0;
    end else if (accept_s && illegal_s && (ecnt_q != {ERRW{1'b1}})) begin
      ecnt_d = ecnt_q + ERRW'(1);
    end else begin
      ecnt_d = ecnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      count_q <= 4'd0;
      err_q   <= 1'b0;
      trunc_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      err_q   <= err_d;
      trunc_q <= trunc_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = valid_q;
  assign out_bcd     = word_q;
  assign out_ndigits = count_q;
  assign out_err     = err_q;
  assign out_trunc   = trunc_q;
  assign err_count   = ecnt_q;

endmodule

// File: tb/tb_excess5_frame_decoder.sv
// Directed and randomized bench for excess5_frame_decoder with a digit-list reference model.
module tb_excess5_frame_decoder;

  localparam int DIGITS = 4;
  localparam int ERRW   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_code = 4'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_bcd;
  logic [3:0]  out_ndigits;
  logic        out_err;
  logic        out_trunc;
  logic [7:0]  err_count;
  logic        clear = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: digits of the open frame, frame flags, expected error count.
  int m_q[$];
  bit m_err = 1'b0;
  bit m_trunc = 1'b0;
  int m_ecnt = 0;

  excess5_frame_decoder #(.DIGITS(DIGITS), .ERRW(ERRW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_bcd(out_bcd), .out_ndigits(out_ndigits),
    .out_err(out_err), .out_trunc(out_trunc), .err_count(err_count),
    .clear(clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_bcd();
    logic [31:0] v = 32'd0;
    foreach (m_q[i]) v = v * 32'd16 + 32'(m_q[i]);
    return v;
  endfunction

  // Present one code and hold it until accepted; called at posedge+1.
  task automatic send(input logic [3:0] c, input logic l);
    int n = 0;
    bit ill;
    in_valid = 1'b1; in_code = c; in_last = l;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    ill = (c < 4'd5) || (c > 4'd14);
    m_q.push_back(ill ? 0 : int'(c) - 5);
    m_err = m_err | ill;
    if (clear) m_ecnt = 0;
    else if (ill && m_ecnt < 255) m_ecnt++;
    m_trunc = !l && (m_q.size() == DIGITS);
  endtask

  // Check a finished frame right after its last accept, hold it, then hand it off.
  task automatic drain(input string tag, input int hold);
    logic [15:0] snap;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_bcd"}, {16'd0, out_bcd}, exp_bcd());
    chk({tag, "_nd"}, {28'd0, out_ndigits}, 32'(m_q.size()));
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, m_err});
    chk({tag, "_trunc"}, {31'd0, out_trunc}, {31'd0, m_trunc});
    chk({tag, "_ecnt"}, {24'd0, err_count}, 32'(m_ecnt));
    chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
    snap = out_bcd;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_bcd"}, {16'd0, out_bcd}, {16'd0, snap});
      chk({tag, "_hold_inrdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_post_bcd"}, {16'd0, out_bcd}, 32'd0);
    chk({tag, "_post_inrdy"}, {31'd0, in_ready}, 32'd1);
    m_q.delete(); m_err = 1'b0; m_trunc = 1'b0;
  endtask

  initial begin
    bit done;
    logic [3:0] c;
    logic l;

    // Reset state.
    #2;
    chk("rst_inrdy", {31'd0, in_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ecnt", {24'd0, err_count}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_inrdy", {31'd0, in_ready}, 32'd1);
    chk("rel_bcd", {16'd0, out_bcd}, 32'd0);

    // Full frame 1,2,3,4.
    send(4'd6, 1'b0); send(4'd7, 1'b0); send(4'd8, 1'b0); send(4'd9, 1'b1);
    chk("t1_bcd_const", {16'd0, out_bcd}, 32'h1234);
    drain("t1", 0);

    // Single digit 9.
    send(4'd14, 1'b1);
    chk("t2_bcd_const", {16'd0, out_bcd}, 32'h0009);
    drain("t2", 0);

    // Illegal codes, then clear.
    send(4'd5, 1'b0); send(4'd3, 1'b0); send(4'd15, 1'b1);
    chk("t3_ecnt_const", {24'd0, err_count}, 32'd2);
    drain("t3", 1);
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0; m_ecnt = 0;
    chk("t3_clear", {24'd0, err_count}, 32'd0);

    // Clear coincident with an illegal accept.
    clear = 1'b1;
    send(4'd0, 1'b1);
    clear = 1'b0;
    chk("clr_win", {24'd0, err_count}, 32'd0);
    drain("clrwin", 0);

    // Truncated frame held for 3 cycles with the next digit waiting.
    send(4'd5, 1'b0); send(4'd6, 1'b0); send(4'd7, 1'b0); send(4'd8, 1'b0);
    chk("t4_bcd_const", {16'd0, out_bcd}, 32'h0123);
    chk("t4_trunc_const", {31'd0, out_trunc}, 32'd1);
    in_valid = 1'b1; in_code = 4'd9; in_last = 1'b0;
    drain("t4", 3);
    send(4'd9, 1'b0); send(4'd5, 1'b1);
    chk("t4_next_const", {16'd0, out_bcd}, 32'h0040);
    drain("t4b", 0);

    // Randomized frames against the model.
    for (int f = 0; f < 40; f++) begin
      done = 1'b0;
      while (!done) begin
        c = 4'($urandom_range(0, 15));
        l = ($urandom_range(0, 3) == 0);
        send(c, l);
        done = l || (m_q.size() == DIGITS);
      end
      drain("rnd", $urandom_range(0, 2));
    end

    // Saturation of the error counter.
    for (int f = 0; f < 75; f++) begin
      for (int d = 0; d < DIGITS; d++) send(4'd0, 1'b0);
      drain("sat", 0);
    end
    chk("sat_const", {24'd0, err_count}, 32'd255);

    // Asynchronous reset mid-frame.
    send(4'd6, 1'b0); send(4'd7, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_inrdy", {31'd0, in_ready}, 32'd0);
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_bcd", {16'd0, out_bcd}, 32'd0);
    chk("mid_nd", {28'd0, out_ndigits}, 32'd0);
    chk("mid_ecnt", {24'd0, err_count}, 32'd0);
    chk("mid_flags", {30'd0, out_err, out_trunc}, 32'd0);
    m_q.delete(); m_err = 1'b0; m_trunc = 1'b0; m_ecnt = 0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_inrdy", {31'd0, in_ready}, 32'd1);
    send(4'd8, 1'b1);
    chk("mid_after_const", {16'd0, out_bcd}, 32'h0003);
    drain("mid", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
